// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master DRAM arbiter (icache refill read port, dcache read/write port).
// Captures single-cycle requests, issues one DRAM command at a time and routes the
// response back to the master that owns the outstanding transaction.
// Build option: define MEM_ARBITER_RR_EN for round-robin arbitration on contention;
// left undefined, the dcache always wins over the icache.
module mem_arbiter #(
  parameter int MEM_SCALE = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_oe,
  input  logic [MEM_SCALE-1:0] i_addr,
  output logic [31:0]          i_rdata,
  output logic                 i_valid,
  input  logic                 d_oe,
  input  logic                 d_we,
  input  logic [MEM_SCALE-1:0] d_addr,
  input  logic [31:0]          d_wdata,
  output logic [31:0]          d_rdata,
  output logic                 d_valid,
  output logic                 dram_oe,
  output logic                 dram_we,
  output logic [MEM_SCALE-1:0] dram_addr,
  output logic [31:0]          dram_wdata,
  input  logic                 dram_ready,
  input  logic [31:0]          dram_rdata,
  input  logic                 dram_valid
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t                 state_reg;
  logic                   owner_reg;
  logic                   i_pend_reg;
  logic [MEM_SCALE-1:0]   i_addr_reg;
  logic                   d_pend_reg;
  logic                   d_we_reg;
  logic [MEM_SCALE-1:0]   d_addr_reg;
  logic [31:0]            d_wdata_reg;
`ifdef MEM_ARBITER_RR_EN
  logic                   rr_ptr_reg;
  logic                   contend;
`endif

  logic                   retire;
  logic                   i_retire;
  logic                   d_retire;
  logic                   issue_window;
  logic                   i_elig;
  logic                   d_elig;
  logic                   grant_d;
  logic                   issue;
  logic [MEM_SCALE-1:0]   i_issue_addr;
  logic                   d_issue_we;
  logic [MEM_SCALE-1:0]   d_issue_addr;
  logic [31:0]            d_issue_wdata;

  // The outstanding transaction completes when DRAM responds while we are waiting.
  assign retire   = (state_reg == WAIT) && dram_valid;
  assign i_retire = retire && (owner_reg == OWN_I);
  assign d_retire = retire && (owner_reg == OWN_D);

  // A command may go out from IDLE, or back-to-back in the response cycle so the
  // next strobe appears the cycle right after dram_valid.
  assign issue_window = (state_reg == IDLE) || retire;

  // Eligibility includes a same-cycle pulse (bypass); the retiring master is excluded
  // because its pend bit still reflects the transaction that is just finishing.
  assign i_elig = issue_window && !i_retire && (i_pend_reg || i_oe);
  assign d_elig = issue_window && !d_retire && (d_pend_reg || d_oe);

`ifdef MEM_ARBITER_RR_EN
  // The pointer only matters (and only moves) when both masters compete.
  assign contend = i_elig && d_elig;
  assign grant_d = d_elig && (!i_elig || (rr_ptr_reg == OWN_D));
`else
  assign grant_d = d_elig;
`endif

  assign issue = dram_ready && (i_elig || d_elig);

  // Latched request wins over the live inputs: a pulse during pending is ignored.
  assign i_issue_addr  = i_pend_reg ? i_addr_reg  : i_addr;
  assign d_issue_we    = d_pend_reg ? d_we_reg    : d_we;
  assign d_issue_addr  = d_pend_reg ? d_addr_reg  : d_addr;
  assign d_issue_wdata = d_pend_reg ? d_wdata_reg : d_wdata;

  // Responses are routed combinationally so the owner sees data with zero added latency.
  assign i_valid = i_retire && !rst;
  assign d_valid = d_retire && !rst;
  assign i_rdata = dram_rdata;
  assign d_rdata = dram_rdata;

  // Request capture, arbitration FSM and registered DRAM command outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      owner_reg   <= OWN_D;
      i_pend_reg  <= 1'b0;
      i_addr_reg  <= '0;
      d_pend_reg  <= 1'b0;
      d_we_reg    <= 1'b0;
      d_addr_reg  <= '0;
      d_wdata_reg <= '0;
      dram_oe     <= 1'b0;
      dram_we     <= 1'b0;
      dram_addr   <= '0;
      dram_wdata  <= '0;
`ifdef MEM_ARBITER_RR_EN
      rr_ptr_reg  <= OWN_D;
`endif
    end else begin
      if (i_retire) begin
        i_pend_reg <= 1'b0;
      end else if (i_oe && !i_pend_reg) begin
        i_pend_reg <= 1'b1;
        i_addr_reg <= i_addr;
      end

      if (d_retire) begin
        d_pend_reg <= 1'b0;
      end else if (d_oe && !d_pend_reg) begin
        d_pend_reg  <= 1'b1;
        d_we_reg    <= d_we;
        d_addr_reg  <= d_addr;
        d_wdata_reg <= d_wdata;
      end

      dram_oe <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (issue) begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (dram_valid && !issue) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (issue) begin
        dram_oe   <= 1'b1;
        owner_reg <= grant_d ? OWN_D : OWN_I;
        dram_we   <= grant_d && d_issue_we;
        dram_addr <= grant_d ? d_issue_addr : i_issue_addr;
        if (grant_d) begin
          dram_wdata <= d_issue_wdata;
        end
`ifdef MEM_ARBITER_RR_EN
        if (contend) begin
          rr_ptr_reg <= grant_d ? OWN_I : OWN_D;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard of expected DRAM commands and
// master responses; a negedge monitor pops and compares whenever the DUT strobes.
module tb_mem_arbiter;

  localparam int MS = 27;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_oe;
  logic [MS-1:0] i_addr;
  logic [31:0]   i_rdata;
  logic          i_valid;
  logic          d_oe;
  logic          d_we;
  logic [MS-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_valid;
  logic          dram_oe;
  logic          dram_we;
  logic [MS-1:0] dram_addr;
  logic [31:0]   dram_wdata;
  logic          dram_ready;
  logic [31:0]   dram_rdata;
  logic          dram_valid;

  mem_arbiter #(.MEM_SCALE(MS)) dut (
    .clk(clk), .rst(rst),
    .i_oe(i_oe), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_oe(d_oe), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .dram_oe(dram_oe), .dram_we(dram_we), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_ready(dram_ready), .dram_rdata(dram_rdata),
    .dram_valid(dram_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int          at;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t cmd_q[$];
  exp_t i_q[$];
  exp_t d_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push_cmd(input int at, input logic we, input logic [31:0] addr,
                          input logic [31:0] data);
    exp_t e;
    e.at = at; e.we = we; e.addr = addr; e.data = data;
    cmd_q.push_back(e);
  endtask

  task automatic push_rsp(input bit is_d, input int at, input logic [31:0] data);
    exp_t e;
    e.at = at; e.we = 1'b0; e.addr = '0; e.data = data;
    if (is_d) d_q.push_back(e);
    else      i_q.push_back(e);
  endtask

  // Monitor: compare every DUT strobe against the head of the matching queue.
  always @(negedge clk) begin
    exp_t e;
    if (dram_oe) begin
      $display("cycle %0d: dram cmd we=%0b addr=0x%07h wdata=0x%08h",
               cyc, dram_we, dram_addr, dram_wdata);
      if (cmd_q.size() == 0) begin
        chk("unexpected_dram_oe", 32'd1, 32'd0);
      end else begin
        e = cmd_q.pop_front();
        chk("cmd_cycle", cyc, e.at);
        chk("cmd_addr", {5'd0, dram_addr}, e.addr);
        chk("cmd_we", {31'd0, dram_we}, {31'd0, e.we});
        if (e.we) chk("cmd_wdata", dram_wdata, e.data);
      end
    end
    if (i_valid) begin
      $display("cycle %0d: icache rsp rdata=0x%08h", cyc, i_rdata);
      chk("i_d_valid_exclusive", {31'd0, d_valid}, 32'd0);
      if (i_q.size() == 0) begin
        chk("unexpected_i_valid", 32'd1, 32'd0);
      end else begin
        e = i_q.pop_front();
        chk("i_rsp_cycle", cyc, e.at);
        chk("i_rdata", i_rdata, e.data);
      end
    end
    if (d_valid) begin
      $display("cycle %0d: dcache rsp rdata=0x%08h", cyc, d_rdata);
      if (d_q.size() == 0) begin
        chk("unexpected_d_valid", 32'd1, 32'd0);
      end else begin
        e = d_q.pop_front();
        chk("d_rsp_cycle", cyc, e.at);
        chk("d_rdata", d_rdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic dram_rsp(input logic [31:0] data);
    dram_valid = 1'b1;
    dram_rdata = data;
    tick();
    dram_valid = 1'b0;
    dram_rdata = '0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_dram_oe"}, {31'd0, dram_oe}, 32'd0);
    chk({tag, "_dram_we"}, {31'd0, dram_we}, 32'd0);
    chk({tag, "_dram_addr"}, {5'd0, dram_addr}, 32'd0);
    chk({tag, "_dram_wdata"}, dram_wdata, 32'd0);
    chk({tag, "_i_valid"}, {31'd0, i_valid}, 32'd0);
    chk({tag, "_d_valid"}, {31'd0, d_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int t;

  initial begin
    rst = 1'b1; i_oe = 0; i_addr = '0; d_oe = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    dram_ready = 1'b1; dram_rdata = '0; dram_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    reset_checks("reset");
    tick();

    // 1: single icache read
    t = cyc;
    i_oe = 1; i_addr = 27'h0000100;
    push_cmd(t + 1, 1'b0, 32'h100, 32'h0);
    push_rsp(1'b0, t + 5, 32'hDEADBEEF);
    tick(); i_oe = 0;
    goto_cyc(t + 5); dram_rsp(32'hDEADBEEF);
    tick(); tick();

    // 2: simultaneous requests, dcache first, icache issued right after response
    t = cyc;
    i_oe = 1; i_addr = 27'h300; d_oe = 1; d_we = 0; d_addr = 27'h200;
    push_cmd(t + 1, 1'b0, 32'h200, 32'h0);
    push_rsp(1'b1, t + 4, 32'hA5A50001);
    push_cmd(t + 5, 1'b0, 32'h300, 32'h0);
    push_rsp(1'b0, t + 8, 32'hA5A50002);
    tick(); i_oe = 0; d_oe = 0;
    goto_cyc(t + 4); dram_rsp(32'hA5A50001);
    goto_cyc(t + 8); dram_rsp(32'hA5A50002);
    tick(); tick();

    // 3: dcache write, icache request arrives during WAIT
    t = cyc;
    d_oe = 1; d_we = 1; d_addr = 27'h40; d_wdata = 32'h12345678;
    push_cmd(t + 1, 1'b1, 32'h40, 32'h12345678);
    push_rsp(1'b1, t + 6, 32'h0000ACED);
    push_cmd(t + 7, 1'b0, 32'h500, 32'h0);
    push_rsp(1'b0, t + 10, 32'h0BADF00D);
    tick(); d_oe = 0; d_we = 0; d_wdata = 32'hFFFFFFFF;
    i_oe = 0;
    goto_cyc(t + 2); i_oe = 1; i_addr = 27'h500;
    tick(); i_oe = 0;
    chk("t3_wdata_held", dram_wdata, 32'h12345678);
    chk("t3_addr_held", {5'd0, dram_addr}, 32'h40);
    goto_cyc(t + 6); dram_rsp(32'h0000ACED);
    goto_cyc(t + 10); dram_rsp(32'h0BADF00D);
    tick(); tick();

    // 4: two contended pairs from a fresh reset
    do_reset();
    tick();
    t = cyc;
    i_oe = 1; i_addr = 27'h600; d_oe = 1; d_we = 0; d_addr = 27'h700;
    push_cmd(t + 1, 1'b0, 32'h700, 32'h0);
    push_rsp(1'b1, t + 3, 32'h44440001);
    push_cmd(t + 4, 1'b0, 32'h600, 32'h0);
    push_rsp(1'b0, t + 6, 32'h44440002);
`ifdef MEM_ARBITER_RR_EN
    push_cmd(t + 9, 1'b0, 32'h610, 32'h0);
    push_rsp(1'b0, t + 11, 32'h44440003);
    push_cmd(t + 12, 1'b0, 32'h710, 32'h0);
    push_rsp(1'b1, t + 14, 32'h44440004);
`else
    push_cmd(t + 9, 1'b0, 32'h710, 32'h0);
    push_rsp(1'b1, t + 11, 32'h44440003);
    push_cmd(t + 12, 1'b0, 32'h610, 32'h0);
    push_rsp(1'b0, t + 14, 32'h44440004);
`endif
    tick(); i_oe = 0; d_oe = 0;
    goto_cyc(t + 3); dram_rsp(32'h44440001);
    goto_cyc(t + 6); dram_rsp(32'h44440002);
    goto_cyc(t + 8);
    i_oe = 1; i_addr = 27'h610; d_oe = 1; d_we = 0; d_addr = 27'h710;
    tick(); i_oe = 0; d_oe = 0;
    goto_cyc(t + 11); dram_rsp(32'h44440003);
    goto_cyc(t + 14); dram_rsp(32'h44440004);
    tick(); tick();

    // 5: DRAM not ready; a repeated pulse while pending must be ignored
    t = cyc;
    dram_ready = 0;
    i_oe = 1; i_addr = 27'h800;
    push_cmd(t + 5, 1'b0, 32'h800, 32'h0);
    push_rsp(1'b0, t + 7, 32'h55550001);
    tick(); i_oe = 0;
    goto_cyc(t + 2); i_oe = 1; i_addr = 27'hBAD;
    tick(); i_oe = 0;
    goto_cyc(t + 4); dram_ready = 1;
    goto_cyc(t + 7); dram_rsp(32'h55550001);
    tick(); tick();

    // 6: reset during WAIT; late response dropped, fresh request served
    t = cyc;
    i_oe = 1; i_addr = 27'h900;
    push_cmd(t + 1, 1'b0, 32'h900, 32'h0);
    tick(); i_oe = 0;
    goto_cyc(t + 3); rst = 1;
    tick(); rst = 0;
    reset_checks("midwait_reset");
    goto_cyc(t + 5); dram_rsp(32'h66660001);
    goto_cyc(t + 6); i_oe = 1; i_addr = 27'h910;
    push_cmd(t + 7, 1'b0, 32'h910, 32'h0);
    push_rsp(1'b0, t + 9, 32'h66660002);
    tick(); i_oe = 0;
    goto_cyc(t + 9); dram_rsp(32'h66660002);
    tick(); tick(); tick();

    chk("cmd_queue_drained", cmd_q.size(), 32'd0);
    chk("i_queue_drained", i_q.size(), 32'd0);
    chk("d_queue_drained", d_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
